// File: rtl/adex_aer_pkg.sv
// Shared widths and serializer state encoding for the AdEx AER spike encoder.
package adex_aer_pkg;

  localparam int unsigned TS_W     = 15;
  localparam int unsigned EVT_W    = 16;
  localparam int unsigned LOST_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } ser_state_e;

endpackage

// File: rtl/adex_aer_fifo.sv
// Synchronous event FIFO; dout shows the head entry whenever the FIFO is not empty.
module adex_aer_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is legal when the head is popped in the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en)         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adex_aer_spike_encoder.sv
// Spike onset detector, timestamping, event FIFO and 2-byte AER serializer.
// Optional windowed spike-rate counter is built when ADEX_AER_RATE_EN is defined.
module adex_aer_spike_encoder
  import adex_aer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIN_LOG2   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spike_i,
  input  logic       tick_i,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       drop_o,
  input  logic       clr_i,
  output logic [7:0] rate_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (WIN_LOG2 < 1) begin : g_bad_win
    $error("WIN_LOG2 must be >= 1");
  end

  logic             spike_q, spike_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             lost_pend_q, lost_pend_d;
  logic             drop_q, drop_d;
  ser_state_e       state_q, state_d;
  logic [EVT_W-1:0] hold_q, hold_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;

  logic             onset, push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [EVT_W-1:0] evt, fifo_dout;

  always_comb begin
    spike_d = spike_i;
    onset   = spike_i & ~spike_q;
    ts_d    = tick_i ? ts_q + TS_W'(1) : ts_q;

    evt                 = '0;
    evt[TS_W-1:0]       = ts_q;
    evt[LOST_BIT]       = lost_pend_q;

    case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_LO:   pop = out_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase

    push = onset && (!fifo_full || pop);
    drop = onset && !push;

    lost_pend_d = lost_pend_q;
    if (push)      lost_pend_d = 1'b0;
    else if (drop) lost_pend_d = 1'b1;

    drop_d = drop_q;
    if (drop)       drop_d = 1'b1;
    else if (clr_i) drop_d = 1'b0;
  end

  adex_aer_fifo #(
    .WIDTH(EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (evt),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (fifo_dout)
  );

  // out_valid/out_data are registered: they reflect the state being entered.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d     = ST_HI;
          hold_d      = fifo_dout;
          out_valid_d = 1'b1;
          out_data_d  = fifo_dout[EVT_W-1:8];
        end
      end
      ST_HI: begin
        if (out_ready) begin
          state_d    = ST_LO;
          out_data_d = hold_q[7:0];
        end
      end
      ST_LO: begin
        if (out_ready) begin
          if (pop) begin
            state_d     = ST_HI;
            hold_d      = fifo_dout;
            out_valid_d = 1'b1;
            out_data_d  = fifo_dout[EVT_W-1:8];
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q     <= 1'b0;
      ts_q        <= '0;
      lost_pend_q <= 1'b0;
      drop_q      <= 1'b0;
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      spike_q     <= spike_d;
      ts_q        <= ts_d;
      lost_pend_q <= lost_pend_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign drop_o    = drop_q;

`ifdef ADEX_AER_RATE_EN
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [7:0]          cnt_q, cnt_d, rate_q, rate_d;

  // A push in the wrap cycle is counted in the reported window and also
  // seeds the next one.
  always_comb begin
    win_d  = tick_i ? win_q + WIN_LOG2'(1) : win_q;
    cnt_d  = (push && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    rate_d = rate_q;
    if (tick_i && win_q == '1) begin
      rate_d = cnt_d;
      cnt_d  = push ? 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      cnt_q  <= '0;
      rate_q <= '0;
    end else begin
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

  assign rate_o = rate_q;
`else
  assign rate_o = '0;
`endif

endmodule

// File: tb/tb_adex_aer_spike_encoder.sv
// Bench for adex_aer_spike_encoder: event-queue reference model checked every cycle,
// plus directed scenarios with literal expected bytes.
module tb_adex_aer_spike_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WINL  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spike_i = 1'b0;
  logic       tick_i = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_i = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       drop_o;
  logic [7:0] rate_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adex_aer_spike_encoder #(
    .FIFO_DEPTH(DEPTH),
    .WIN_LOG2  (WINL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spike_i  (spike_i),
    .tick_i   (tick_i),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_o   (drop_o),
    .clr_i    (clr_i),
    .rate_o   (rate_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of pending event words, word being serialized and
  // number of its bytes still to go out.
  logic [15:0] mq[$];
  logic [15:0] m_hold = '0;
  int          m_rem = 0;
  logic [14:0] m_ts = '0;
  logic        m_prev = 1'b0;
  logic        m_lost = 1'b0;
  logic        m_drop = 1'b0;
  int          m_win = 0;
  int          m_cnt = 0;
  int          m_rate = 0;
  bit          x_xfer, x_pop, x_onset, x_push;
  logic [7:0]  got[$];

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_hold = '0; m_rem = 0; m_ts = '0; m_prev = 1'b0;
        m_lost = 1'b0; m_drop = 1'b0; m_win = 0; m_cnt = 0; m_rate = 0;
      end else begin
        x_xfer  = (m_rem > 0) && out_ready;
        x_pop   = (mq.size() > 0) && (m_rem == 0 || (m_rem == 1 && x_xfer));
        x_onset = spike_i && !m_prev;
        x_push  = x_onset && (mq.size() < DEPTH || x_pop);
        if (x_xfer) m_rem--;
        if (x_pop) begin
          m_hold = mq.pop_front();
          m_rem  = 2;
        end
        if (x_push) begin
          mq.push_back({m_lost, m_ts});
          m_lost = 1'b0;
        end
        if (x_onset && !x_push) begin
          m_lost = 1'b1;
          m_drop = 1'b1;
        end else if (clr_i) begin
          m_drop = 1'b0;
        end
`ifdef ADEX_AER_RATE_EN
        if (x_push && m_cnt < 255) m_cnt++;
        if (tick_i) begin
          if (m_win == (1 << WINL) - 1) begin
            m_rate = m_cnt;
            m_cnt  = x_push ? 1 : 0;
            m_win  = 0;
          end else begin
            m_win++;
          end
        end
`endif
        if (tick_i) m_ts = m_ts + 15'd1;
        m_prev = spike_i;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", out_valid, m_rem > 0);
        if (m_rem > 0) chk("out_data", out_data, (m_rem == 2) ? m_hold[15:8] : m_hold[7:0]);
        chk("drop_o", drop_o, m_drop);
        chk("rate_o", rate_o, m_rate);
        if (out_valid && out_ready) got.push_back(out_data);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; spike_i = 1'b0; tick_i = 1'b0; clr_i = 1'b0; out_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      if (!out_valid && m_rem == 0 && mq.size() == 0) done = 1'b1;
    end
    chk("drain_done", done, 1'b1);
  endtask

  task automatic pulse_spike(input logic with_tick);
    spike_i = 1'b1; tick_i = with_tick;
    step(1);
    spike_i = 1'b0; tick_i = 1'b0;
    step(1);
  endtask

  initial begin : stim
    // Reset values
    rst_n = 1'b0;
    step(2);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_drop", drop_o, 1'b0);
    chk("rst_rate", rate_o, 8'h00);
    rst_n = 1'b1;
    step(1);

    // Single spike at ts 5, level held 3 cycles
    tick_i = 1'b1;
    step(5);
    tick_i = 1'b0;
    out_ready = 1'b1;
    got.delete();
    spike_i = 1'b1;
    step(1);
    chk("lat_edge_n", out_valid, 1'b0);
    step(1);
    chk("lat_edge_n1_valid", out_valid, 1'b1);
    chk("lat_edge_n1_data", out_data, 8'h00);
    step(1);
    spike_i = 1'b0;
    drain(20);
    chk("single_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("single_hi", got[0], 8'h00);
      chk("single_lo", got[1], 8'h05);
    end

    // Backpressure on the HI byte
    out_ready = 1'b0;
    got.delete();
    pulse_spike(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 8'h00);
    end
    drain(20);
    chk("bp_count", got.size(), 2);
    if (got.size() == 2) chk("bp_lo", got[1], 8'h05);

    // Overflow: onsets at ts 1..6 with consumer stalled
    do_reset();
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
    for (int i = 0; i < 6; i++) pulse_spike(1'b1);
    chk("ovf_drop", drop_o, 1'b1);
    got.delete();
    drain(100);
    chk("ovf_count", got.size(), 10);
    if (got.size() == 10) begin
      for (int k = 0; k < 4; k++) begin
        chk("ovf_hi", got[2*k], 8'h00);
        chk("ovf_lo", got[2*k+1], k + 1);
      end
    end
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    chk("clr_drop", drop_o, 1'b0);
    pulse_spike(1'b0);
    drain(20);
    chk("lost_count", got.size(), 12);
    if (got.size() == 12) begin
      chk("lost_hi", got[10], 8'h80);
      chk("lost_lo", got[11], 8'h07);
    end

    // Full FIFO with onset coinciding with the LO-byte pop
    do_reset();
    got.delete();
    for (int i = 0; i < 5; i++) pulse_spike(1'b0);
    chk("full_nodrop_pre", drop_o, 1'b0);
    out_ready = 1'b1;
    step(1);
    spike_i = 1'b1;
    step(1);
    spike_i = 1'b0;
    chk("full_pop_nodrop", drop_o, 1'b0);
    drain(40);
    chk("full_pop_count", got.size(), 12);

    // Timestamp wrap
    do_reset();
    tick_i = 1'b1;
    step(32767);
    out_ready = 1'b1;
    got.delete();
    spike_i = 1'b1;
    step(1);
    tick_i = 1'b0; spike_i = 1'b0;
    step(1);
    spike_i = 1'b1;
    step(1);
    spike_i = 1'b0;
    drain(20);
    chk("wrap_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("wrap_b0", got[0], 8'h7F);
      chk("wrap_b1", got[1], 8'hFF);
      chk("wrap_b2", got[2], 8'h00);
      chk("wrap_b3", got[3], 8'h00);
    end

    // Rate window
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) pulse_spike(1'b0);
    tick_i = 1'b1;
    step(16);
    tick_i = 1'b0;
`ifdef ADEX_AER_RATE_EN
    chk("rate_3", rate_o, 8'd3);
`else
    chk("rate_off", rate_o, 8'd0);
`endif
    for (int i = 0; i < 300; i++) pulse_spike(1'b0);
    tick_i = 1'b1;
    step(16);
    tick_i = 1'b0;
`ifdef ADEX_AER_RATE_EN
    chk("rate_sat", rate_o, 8'd255);
`else
    chk("rate_off2", rate_o, 8'd0);
`endif
    drain(20);

    // Reset during a stalled word clears the bus immediately
    out_ready = 1'b0;
    pulse_spike(1'b0);
    step(1);
    chk("midrst_pre", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Randomized traffic with occasional mid-operation reset
    for (int i = 0; i < 4000; i++) begin
      spike_i   = ($urandom_range(0, 2) != 0);
      tick_i    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_i     = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step(1);
    end
    rst_n = 1'b1; spike_i = 1'b0; tick_i = 1'b0; clr_i = 1'b0;
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
